adc_sample_packer: RTL

- Consumes the byte stream that the converter front-end writes toward its FIFO (byte strobe plus 8-bit data, 4 bytes per sample, LSB first).
- Reassembles bytes into 32-bit samples and detects framing gaps.
- Buffers samples in a small sync FIFO with a valid/ready output to the host-side packetizer.
- Maintains sample, drop and framing-error counters for the status registers.

---
 rtl/da_pkg.sv | 16 +
 rtl/adc_sample_packer_if.sv | 30 +++
 rtl/sample_fifo.sv | 64 ++++++
 rtl/adc_sample_packer.sv | 116 +++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// Shared constants and helpers for the ADC sample packer.
//   DEF_BYTES_PER_SAMPLE / DEF_GAP_TIMEOUT : default framing parameters
//   SAMPLE_CNT_W / ERR_CNT_W               : status counter widths
//   sat_inc                                : saturating increment for error/drop counters
package da_pkg;

    localparam int unsigned DEF_BYTES_PER_SAMPLE = 4;
    localparam int unsigned DEF_GAP_TIMEOUT      = 16;
    localparam int unsigned SAMPLE_CNT_W         = 32;
    localparam int unsigned ERR_CNT_W            = 16;

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/adc_sample_packer_if.sv
// Byte-in / sample-out stream bundle for the ADC sample packer.
//   byte_valid, byte_data     : front-end byte strobe and value
//   sample_data, sample_valid : head-of-buffer sample toward the packetizer
//   sample_ready              : packetizer accepts the head sample
// slave is the packer's view; master is the surrounding environment.
interface adc_sample_packer_if #(
    parameter int unsigned SAMPLE_W = 32
);
    logic                byte_valid;
    logic [7:0]          byte_data;
    logic [SAMPLE_W-1:0] sample_data;
    logic                sample_valid;
    logic                sample_ready;

    modport master (
        output byte_valid,
        output byte_data,
        output sample_ready,
        input  sample_data,
        input  sample_valid
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        input  sample_ready,
        output sample_data,
        output sample_valid
    );
endinterface

// File: rtl/sample_fifo.sv
// Generic synchronous FIFO.
//   clk, reset           : clock, synchronous active-high reset
//   push, push_data      : write request; ignored when full unless a pop happens too
//   pop                  : read request; ignored when empty
//   full, empty          : occupancy flags
//   head_data            : oldest entry, 0 when empty
// DEPTH must be a power of 2 and at least 2.
module sample_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra pointer bit distinguishes full from empty when the address bits match.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop  = pop && !empty;
        // A simultaneous pop frees the slot the push needs.
        do_push = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: head_data is masked whenever the pointers say empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/adc_sample_packer.sv
// Reassembles the converter's byte stream (LSB first) into samples, aborts partial samples
// after a run of idle cycles, buffers completed samples and keeps status counters.
//   clk, reset      : clock, synchronous active-high reset
//   bus             : byte input and valid/ready sample output (slave modport)
//   sample_count    : samples accepted into the buffer, wraps
//   drop_count      : completed samples lost to a full buffer, saturates
//   frame_err_count : partial samples aborted by the gap timeout, saturates
module adc_sample_packer
    import da_pkg::*;
#(
    parameter int unsigned BYTES_PER_SAMPLE = DEF_BYTES_PER_SAMPLE,
    parameter int unsigned GAP_TIMEOUT      = DEF_GAP_TIMEOUT,
    parameter int unsigned DEPTH            = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    adc_sample_packer_if.slave      bus,
    output logic [SAMPLE_CNT_W-1:0] sample_count,
    output logic [ERR_CNT_W-1:0]    drop_count,
    output logic [ERR_CNT_W-1:0]    frame_err_count
);

    localparam int unsigned SAMPLE_W = 8 * BYTES_PER_SAMPLE;
    localparam int unsigned IDX_W    = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;
    localparam int unsigned GAP_W    = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;

    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [SAMPLE_W-1:0]     asm_q, asm_d;
    logic [SAMPLE_CNT_W-1:0] sample_count_q;
    logic [ERR_CNT_W-1:0]    drop_count_q, frame_err_count_q;

    logic push, abort, pop, push_accept, drop;
    logic fifo_full, fifo_empty;

    // Byte assembly and gap timer.
    always_comb begin
        idx_d = idx_q;
        gap_d = gap_q;
        asm_d = asm_q;
        push  = 1'b0;
        abort = 1'b0;
        if (bus.byte_valid) begin
            asm_d[8*idx_q +: 8] = bus.byte_data;
            gap_d = '0;
            if (idx_q == IDX_W'(BYTES_PER_SAMPLE - 1)) begin
                idx_d = '0;
                push  = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (idx_q != '0) begin
            // gap_q holds the idle cycles already seen, so this is the (gap_q+1)-th.
            if (gap_q == GAP_W'(GAP_TIMEOUT - 1)) begin
                idx_d = '0;
                gap_d = '0;
                abort = 1'b1;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end else begin
            gap_d = '0;
        end
    end

    always_comb begin
        pop         = bus.sample_valid && bus.sample_ready;
        push_accept = push && (!fifo_full || pop);
        drop        = push && fifo_full && !pop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q             <= '0;
            gap_q             <= '0;
            asm_q             <= '0;
            sample_count_q    <= '0;
            drop_count_q      <= '0;
            frame_err_count_q <= '0;
        end else begin
            idx_q <= idx_d;
            gap_q <= gap_d;
            asm_q <= asm_d;
            if (push_accept) begin
                sample_count_q <= sample_count_q + 1'b1;
            end
            if (drop) begin
                drop_count_q <= sat_inc(drop_count_q);
            end
            if (abort) begin
                frame_err_count_q <= sat_inc(frame_err_count_q);
            end
        end
    end

    // asm_d already carries the final lane, so the word is pushed on the final-byte edge.
    sample_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (asm_d),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (bus.sample_data)
    );

    assign bus.sample_valid = !fifo_empty;
    assign sample_count     = sample_count_q;
    assign drop_count       = drop_count_q;
    assign frame_err_count  = frame_err_count_q;

endmodule
